trace_uart_tx: RTL and testbench
================================

Name: trace_uart_tx

Overview:
- Debug-trace serialiser directly downstream of the CPU top level.
- Consumes the CPU's SYNC strobe and DATA_FINAL byte; captures one byte per opcode fetch into a small FIFO.
- Sends each captured byte as an 8-bit asynchronous serial frame on TX to a host terminal.
- Complements the 7-segment output with a full instruction trace, without stalling the CPU.

Parameters:
- CLK_FREQ, 50000000, CLK frequency in Hz.
- BAUD, 115200, serial bit rate. DIV = CLK_FREQ/BAUD (integer division) must be ≥ 2.
- FIFO_DEPTH, 16, capture FIFO entries; power of two, ≥ 2.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- SYNC  in  1  CPU opcode-fetch strobe.
- DATA_FINAL  in  8  CPU byte to trace.
- TX  out  1  serial line; idles high.
- BUSY  out  1  high while a frame is on the line or the FIFO is non-empty.
- OVERFLOW  out  1  sticky flag: a capture was dropped because the FIFO was full.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (RESET=0 at a rising edge):
  - TX=1, BUSY=0, OVERFLOW=0, FIFO_COUNT=0.
  - FSM goes to IDLE; baud counter, bit index and SYNC history register are cleared.
  - Reset mid-frame aborts the frame; TX returns to 1 on the next edge.
- Capture:
  - SYNC is registered as sync_q.
  - Push request = SYNC & ~sync_q (rising edge only). DATA_FINAL is sampled on that same cycle.
  - A SYNC held high for several cycles gives exactly one push.
- FIFO:
  - Circular buffer with read and write pointers that wrap at FIFO_DEPTH.
  - A push is accepted if FIFO_COUNT < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves FIFO_COUNT unchanged.
  - Push while full with no pop: the data is discarded and OVERFLOW is set to 1. It stays 1 until reset.
  - Pop while empty never occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX=1. If FIFO_COUNT>0, pop into the shift register, clear the baud counter, go to START.
  - START: TX=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: TX = shift[0]. After DIV cycles, shift right and increment the bit index. After bit 7, go to PARITY if the feature is enabled, otherwise to STOP.
  - PARITY: TX = even parity (XOR of the 8 data bits) for DIV cycles, then go to STOP.
  - STOP: TX=1 for DIV cycles, then go to IDLE.
- Timing:
  - Baud counter counts 0..DIV-1; the bit period ends when the counter reaches DIV-1.
  - The first START cycle follows the IDLE pop cycle, so latency from push to TX falling is 2 cycles when the FIFO was empty and the line idle.
  - Back-to-back bytes: IDLE lasts exactly 1 cycle between STOP and the next START.
- TX is driven from a register (no combinational glitches).
- BUSY = (state != IDLE) | (FIFO_COUNT != 0), registered.

Optional Feature:
- Macro TRACE_PARITY_EN.
- Defined: 11-bit frame (start, 8 data LSB first, even parity, stop); PARITY state is present.
- Undefined: 10-bit frame (8N1); PARITY state and parity logic are not synthesised.

Decomposition:
- Shared package trace_pkg holds:
  - FSM state enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - IDLE line level constant (1'b1);
  - DIV computation function.
- One sub-module, trace_fifo: synchronous FIFO, parameterised by width 8 and FIFO_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same CLK and active-low synchronous RESET.
- The FSM, baud counter and edge detector stay in the top level.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so DIV=10; FIFO_DEPTH=4):
- Reset: hold RESET=0 for 3 cycles with SYNC toggling → TX=1, BUSY=0, OVERFLOW=0, FIFO_COUNT=0 throughout; no frame after release.
- Single byte: SYNC pulse, DATA_FINAL=8'hA5 → TX falls 2 cycles later. Bits sampled every 10 cycles are 0, 1,0,1,0,0,1,0,1, then parity 0 if TRACE_PARITY_EN, then 1. BUSY drops when IDLE is re-entered.
- Held SYNC: SYNC high for 25 cycles with DATA_FINAL=8'h3C → exactly one frame carrying 8'h3C; FIFO_COUNT peaks at 1.
- Back-to-back: SYNC edges 3 cycles apart carrying 8'h01, 8'h02, 8'h03 → three frames in order, with exactly one idle-high cycle between the stop bit and the next start bit.
- Overflow: 6 SYNC edges (8'h10..8'h15) within 12 cycles → bytes 10, 11, 12, 13, 14 transmitted (one popped early), 8'h15 dropped, OVERFLOW=1 and still set after the FIFO drains.
- Reset mid-frame: assert RESET during the DATA bit 4 of 8'hFF → TX=1 on the next edge, FIFO_COUNT=0, no further frames.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: FSM state encoding, idle line level and baud divisor helper shared by the trace UART.
package trace_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous circular-buffer FIFO holding captured trace bytes until the UART takes them.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic wr_en;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // a pop in the same cycle frees the slot the write lands in
    assign wr_en = push & (~full | pop);
    assign dout  = mem[rd_ptr];
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/trace_uart_tx.sv
// trace_uart_tx: captures one CPU byte per opcode fetch and streams it out as an async serial frame.
// Define TRACE_PARITY_EN for an 11-bit frame with even parity; the default is 8N1.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          SYNC,
    input  logic [7:0]                    DATA_FINAL,
    output logic                          TX,
    output logic                          BUSY,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    state_t state;
    logic [CW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic [7:0] fifo_dout;
    logic sync_q;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic bit_end;
`ifdef TRACE_PARITY_EN
    logic parity;
`endif
    assign push    = SYNC & ~sync_q;
    assign pop     = (state == IDLE) & ~fifo_empty;
    assign bit_end = baud == BAUD_LAST;

    trace_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .din   (DATA_FINAL),
        .dout  (fifo_dout),
        .count (FIFO_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TX is loaded with the level of the state being entered, so it is glitch-free and in step with state
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            sync_q   <= 1'b0;
            shift    <= '0;
            TX       <= LINE_IDLE;
            BUSY     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            sync_q <= SYNC;
            BUSY   <= (state != IDLE) | (FIFO_COUNT != '0);
            if (push & fifo_full & ~pop) OVERFLOW <= 1'b1;
            baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
            case (state)
                IDLE: begin
                    TX <= LINE_IDLE;
                    if (pop) begin
                        shift <= fifo_dout;
                        state <= START;
                        TX    <= 1'b0;
`ifdef TRACE_PARITY_EN
                        parity <= ^fifo_dout;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        TX      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef TRACE_PARITY_EN
                            state <= PARITY;
                            TX    <= parity;
`else
                            state <= STOP;
                            TX    <= LINE_IDLE;
`endif
                        end else begin
                            TX <= shift[1];
                        end
                    end
                end
`ifdef TRACE_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        TX    <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        TX    <= LINE_IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= LINE_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trace_uart_tx.sv
// tb_trace_uart_tx: directed stimulus with a byte scoreboard checked against frames decoded from TX.
`timescale 1ns/1ps
module tb_trace_uart_tx;
    localparam int DIV = 10;
`ifdef TRACE_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic SYNC = 1'b0;
    logic [7:0] DATA_FINAL = 8'h00;
    logic TX;
    logic BUSY;
    logic OVERFLOW;
    logic [2:0] FIFO_COUNT;
    int n_pass = 0;
    int n_fail = 0;
    int frames = 0;
    logic [7:0] exp_q[$];
    int gaps[$];

    always #5 CLK = ~CLK;

    trace_uart_tx #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SYNC       (SYNC),
        .DATA_FINAL (DATA_FINAL),
        .TX         (TX),
        .BUSY       (BUSY),
        .OVERFLOW   (OVERFLOW),
        .FIFO_COUNT (FIFO_COUNT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit kept);
        DATA_FINAL = b;
        SYNC = 1'b1;
        if (kept) exp_q.push_back(b);
        tick(1);
        SYNC = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (frames < n && k < 3000) begin
            tick(1);
            k++;
        end
        check(tag, frames, n);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (BUSY !== 1'b0 && k < 500) begin
            tick(1);
            k++;
        end
        check(tag, BUSY, 0);
    endtask

    // frame decoder: samples the middle of each bit after a falling edge of TX
    initial begin : monitor
        int c;
        int j;
        int high_run;
        bit in_frame;
        logic [7:0] b;
        logic [7:0] e;
        c = 0;
        high_run = 0;
        in_frame = 1'b0;
        b = '0;
        forever begin
            @(negedge CLK);
            if (RESET !== 1'b1) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (TX === 1'b0) begin
                    gaps.push_back(high_run);
                    in_frame = 1'b1;
                    c = 0;
                end
            end else begin
                c++;
            end
            high_run = (TX === 1'b1) ? high_run + 1 : 0;
            if (in_frame && (c % DIV) == DIV / 2) begin
                j = c / DIV;
                if (j == 0) check("start_bit", TX, 0);
                else if (j <= 8) b[j-1] = TX;
                else if (j == NBITS - 1) begin
                    check("stop_bit", TX, 1);
                    frames++;
                    in_frame = 1'b0;
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_data", b, e);
                    end
                end else begin
                    check("parity_bit", TX, ^b);
                end
            end
        end
    end

    initial begin
        int peak;
        RESET = 1'b0;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            SYNC = ~SYNC;
            DATA_FINAL = 8'h5A;
            tick(1);
            check("rst_tx", TX, 1);
            check("rst_busy", BUSY, 0);
            check("rst_overflow", OVERFLOW, 0);
            check("rst_count", FIFO_COUNT, 0);
        end
        SYNC = 1'b0;
        RESET = 1'b1;
        tick(40);
        check("rst_no_frame", frames, 0);
        check("rst_line_idle", TX, 1);

        send(8'hA5, 1'b1);
        check("a5_count", FIFO_COUNT, 1);
        check("a5_tx_before", TX, 1);
        tick(1);
        check("a5_tx_fall", TX, 0);
        check("a5_busy", BUSY, 1);
        wait_frames(1, "a5_frame");
        wait_idle("a5_idle");
        check("a5_queue_empty", exp_q.size(), 0);

        DATA_FINAL = 8'h3C;
        SYNC = 1'b1;
        exp_q.push_back(8'h3C);
        peak = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
        end
        SYNC = 1'b0;
        check("held_peak", peak, 1);
        wait_frames(2, "held_frame");
        tick(150);
        check("held_one_frame", frames, 2);
        wait_idle("held_idle");

        gaps.delete();
        send(8'h01, 1'b1);
        tick(2);
        send(8'h02, 1'b1);
        tick(2);
        send(8'h03, 1'b1);
        wait_frames(5, "b2b_frames");
        check("b2b_gap_count", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("b2b_gap1", gaps[1], DIV + 1);
            check("b2b_gap2", gaps[2], DIV + 1);
        end
        wait_idle("b2b_idle");

        for (int i = 0; i < 6; i++) begin
            send(8'h10 + 8'(i), i < 5);
            if (i == 4) check("ovf_not_yet", OVERFLOW, 0);
            tick(1);
        end
        check("ovf_set", OVERFLOW, 1);
        check("ovf_count_full", FIFO_COUNT, 4);
        wait_frames(10, "ovf_frames");
        wait_idle("ovf_idle");
        check("ovf_sticky", OVERFLOW, 1);
        check("ovf_queue_empty", exp_q.size(), 0);

        send(8'hFF, 1'b1);
        tick(1);
        send(8'h77, 1'b1);
        tick(50);
        check("midrst_count_before", FIFO_COUNT, 1);
        RESET = 1'b0;
        tick(1);
        check("midrst_tx", TX, 1);
        check("midrst_count", FIFO_COUNT, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_overflow", OVERFLOW, 0);
        exp_q.delete();
        RESET = 1'b1;
        tick(300);
        check("midrst_no_frames", frames, 10);
        check("midrst_line_idle", TX, 1);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
